spi_slave: RTL and testbench

Target-side SPI endpoint, the far end of our 16-bit SPI master link. It oversamples the incoming `ss`/`sck`/`mosi` lines in the system clock domain and shifts 16-bit words LSB first. Each received word is presented on `rx_data` with a one-cycle strobe, and the reply word offered on `tx_data` is returned on `miso`. It sits behind the FPGA pins on the peripheral side of the board link.

---
 rtl/spi_slave.sv | 174 +++++++++++++++++
 tb/tb_spi_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: 16-bit SPI target endpoint, LSB first.
// The ss/sck/mosi pins are oversampled in the clk domain and their edges
// are detected there. Received words appear on rx_data with a one-cycle
// rx_strobe. The reply word is taken from tx_data/tx_valid and shifted out
// on miso.
//
// Handshake: tx_data is offered while tx_valid is high. The source holds it
// until tx_accept pulses for one cycle, which marks the cycle in which the
// word was copied into the reply shifter. Words are taken at the ss fall and
// at every word boundary. When tx_valid is low at a load point, an all-ones
// word is sent and no accept occurs. rx_strobe has no backpressure.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ss,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [15:0] rx_data,
  output logic        rx_strobe,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_accept,
  output logic        frame_error,
  output logic        dbg_active
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  // Fills with ones after reset. Once the top bit is set, the synchronizer
  // outputs hold real pin samples rather than their reset values.
  logic [SYNC_STAGES-1:0] sync_ok_q;
  logic                   ss_prev_q;
  logic                   sck_prev_q;

  logic ss_s, sck_s, mosi_s;
  logic ss_fall, ss_rise, sck_rise, sck_fall;

  state_t      state_q;
  logic        armed_q;
  logic [3:0]  bit_cnt_q;
  // Only the upper 15 bits of the receive shifter are kept. The oldest bit
  // would be shifted out at the same edge that completes the word, so it is
  // never visible.
  logic [14:0] rx_shift_q;
  logic [15:0] tx_shift_q;
  logic        miso_q;
  logic [15:0] rx_data_q;
  logic        rx_strobe_q;
  logic        tx_accept_q;
  logic        frame_error_q;

  logic [15:0] load_word;
  logic [15:0] rx_word;

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign ss_fall  = ss_prev_q & ~ss_s;
  assign ss_rise  = ~ss_prev_q & ss_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  assign load_word = tx_valid ? tx_data : 16'hFFFF;
  assign rx_word   = {mosi_s, rx_shift_q};

  assign miso        = miso_q;
  assign miso_oe     = (state_q == ST_ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_strobe   = rx_strobe_q;
  assign tx_accept   = tx_accept_q;
  assign frame_error = frame_error_q;
  assign dbg_active  = (state_q == ST_ACTIVE);

  // Pin synchronizers, previous-cycle copies for edge detection, and the
  // flag that marks when the synchronized values are real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '1;
      sync_ok_q   <= '0;
      ss_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sync_ok_q   <= {sync_ok_q[SYNC_STAGES-2:0], 1'b1};
      ss_prev_q   <= ss_s;
      sck_prev_q  <= sck_s;
    end
  end

  // Frame FSM: shifters, bit counter, registered miso and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      armed_q       <= 1'b0;
      bit_cnt_q     <= 4'd0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b1;
      rx_data_q     <= 16'h0000;
      rx_strobe_q   <= 1'b0;
      tx_accept_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_strobe_q   <= 1'b0;
      tx_accept_q   <= 1'b0;
      frame_error_q <= 1'b0;

      // Arm only on a real high sample, so ss held low through reset
      // cannot start a frame.
      if (sync_ok_q[SYNC_STAGES-1] && ss_s) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b1;
          bit_cnt_q <= 4'd0;
          if (ss_fall && armed_q) begin
            state_q     <= ST_ACTIVE;
            tx_shift_q  <= load_word;
            tx_accept_q <= tx_valid;
            miso_q      <= load_word[0];
          end
        end

        ST_ACTIVE: begin
          if (ss_rise) begin
            // An ss rise wins over a coincident sck rise.
            state_q    <= ST_IDLE;
            miso_q     <= 1'b1;
            bit_cnt_q  <= 4'd0;
            rx_shift_q <= '0;
            if (bit_cnt_q != 4'd0) begin
              frame_error_q <= 1'b1;
            end
          end else if (sck_rise) begin
            rx_shift_q <= rx_word[15:1];
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              rx_data_q   <= rx_word;
              rx_strobe_q <= 1'b1;
              tx_shift_q  <= load_word;
              tx_accept_q <= tx_valid;
            end else begin
              tx_shift_q <= {1'b1, tx_shift_q[15:1]};
            end
          end else if (sck_fall) begin
            miso_q <= tx_shift_q[0];
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a directed SPI master drives frames. A monitor
// compares each rx_strobe against an expected-word queue, counts tx_accept
// and frame_error pulses, and feeds reply words from a source queue.
module tb_spi_slave;

  localparam int S    = 2;
  localparam int HALF = 6;

  logic        clk;
  logic        reset;
  logic        ss;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] rx_data;
  logic        rx_strobe;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_accept;
  logic        frame_error;
  logic        dbg_active;

  logic [15:0] exp_q[$];
  logic [15:0] tx_src_q[$];

  int n_cmp   = 0;
  int n_err   = 0;
  int acc_cnt = 0;
  int fe_cnt  = 0;

  spi_slave #(.SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .ss          (ss),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_accept   (tx_accept),
    .frame_error (frame_error),
    .dbg_active  (dbg_active)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: shifts nbits of w LSB first and samples miso just before each sck rise.
  task automatic xfer_bits(input logic [15:0] w, input int nbits, output logic [15:0] got);
    got = 16'hFFFF;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[i];
      clks(HALF);
      got[i] = miso;
      sck = 1'b1;
      clks(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] exp_reply, input string name);
    logic [15:0] got;
    exp_q.push_back(w);
    xfer_bits(w, 16, got);
    check(name, got, exp_reply);
  endtask

  task automatic frame_start();
    ss = 1'b0;
    clks(HALF);
  endtask

  task automatic frame_end();
    clks(8);
    ss = 1'b1;
    clks(10);
  endtask

  // Monitor: scoreboard for rx words, pulse counters, reply-word source.
  initial begin
    logic [15:0] e;
    tx_valid = 1'b0;
    tx_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rx_strobe) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got strobe with %h expected no strobe", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e);
        end
      end
      if (tx_accept) begin
        acc_cnt++;
        if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
      end
      if (frame_error) fe_cnt++;
      tx_valid = (tx_src_q.size() > 0);
      tx_data  = tx_valid ? tx_src_q[0] : 16'h0000;
    end
  end

  // Stimulus.
  initial begin
    int acc0, fe0;
    logic [15:0] got;
    reset = 1'b1;
    ss    = 1'b1;
    sck   = 1'b0;
    mosi  = 1'b1;
    clks(3);
    check("reset_miso", {15'd0, miso}, 16'h0001);
    check("reset_miso_oe", {15'd0, miso_oe}, 16'h0000);
    check("reset_rx_data", rx_data, 16'h0000);
    check("reset_rx_strobe", {15'd0, rx_strobe}, 16'h0000);
    check("reset_tx_accept", {15'd0, tx_accept}, 16'h0000);
    check("reset_frame_error", {15'd0, frame_error}, 16'h0000);
    reset = 1'b0;
    clks(10);

    // Basic frame with a reply word.
    acc0 = acc_cnt; fe0 = fe_cnt;
    tx_src_q.push_back(16'h1234);
    clks(2);
    frame_start();
    check("basic_miso_oe", {15'd0, miso_oe}, 16'h0001);
    send_word(16'hA55A, 16'h1234, "basic_miso_word");
    frame_end();
    check("basic_accepts", 16'(acc_cnt - acc0), 16'd1);
    check("basic_frame_errors", 16'(fe_cnt - fe0), 16'd0);
    check("basic_idle_miso_oe", {15'd0, miso_oe}, 16'h0000);

    // No reply word.
    acc0 = acc_cnt; fe0 = fe_cnt;
    frame_start();
    send_word(16'h3C96, 16'hFFFF, "noreply_miso_word");
    frame_end();
    check("noreply_accepts", 16'(acc_cnt - acc0), 16'd0);
    check("noreply_frame_errors", 16'(fe_cnt - fe0), 16'd0);

    // Back-to-back words under one ss low.
    acc0 = acc_cnt; fe0 = fe_cnt;
    tx_src_q.push_back(16'hBEEF);
    tx_src_q.push_back(16'hCAFE);
    clks(2);
    frame_start();
    send_word(16'h0001, 16'hBEEF, "b2b_miso_word0");
    send_word(16'h8000, 16'hCAFE, "b2b_miso_word1");
    frame_end();
    check("b2b_accepts", 16'(acc_cnt - acc0), 16'd2);
    check("b2b_frame_errors", 16'(fe_cnt - fe0), 16'd0);

    // Aborted word after 7 bits.
    acc0 = acc_cnt; fe0 = fe_cnt;
    frame_start();
    xfer_bits(16'h5555, 7, got);
    clks(HALF);
    ss = 1'b1;
    clks(10);
    check("abort_frame_errors", 16'(fe_cnt - fe0), 16'd1);
    check("abort_rx_data", rx_data, 16'h8000);
    check("abort_miso", {15'd0, miso}, 16'h0001);
    check("abort_miso_oe", {15'd0, miso_oe}, 16'h0000);
    check("abort_accepts", 16'(acc_cnt - acc0), 16'd0);

    // ss rise coincident with the 16th sck rise.
    fe0 = fe_cnt;
    frame_start();
    xfer_bits(16'h0F0F, 15, got);
    mosi = 1'b0;
    clks(HALF);
    sck = 1'b1;
    ss  = 1'b1;
    clks(HALF);
    sck = 1'b0;
    clks(10);
    check("simul_frame_errors", 16'(fe_cnt - fe0), 16'd1);
    check("simul_rx_data", rx_data, 16'h8000);

    // Reset with ss held low while sck toggles.
    ss    = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sck = ~sck;
      clks(HALF);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sck  = ~sck;
      clks(HALF);
      check("rstlow_miso_oe", {15'd0, miso_oe}, 16'h0000);
    end
    sck = 1'b0;
    clks(HALF);
    check("rstlow_rx_data", rx_data, 16'h0000);
    fe0 = fe_cnt;
    ss = 1'b1;
    clks(10);
    frame_start();
    send_word(16'h00FF, 16'hFFFF, "rstlow_miso_word");
    frame_end();
    check("rstlow_frame_errors", 16'(fe_cnt - fe0), 16'd0);

    clks(5);
    check("rx_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
